fifo_stream_reader: RTL



---
 rtl/fifo_rd_pkg.sv | 20 ++
 rtl/fifo_rd_skid.sv | 44 ++++
 rtl/fifo_stream_reader.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int BUF_DEPTH = 2;
  localparam int STAT_W    = 32;

  typedef logic [1:0] occ_t;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer for the FIFO stream reader.
// Circular buffer: push writes the tail, pop advances the head. The reader
// guarantees push never happens when full and pop never happens when empty.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage, pointers and occupancy; simultaneous push+pop leaves occ unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + occ_t'(push) - occ_t'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO: issues fifo_r_en, captures the
// returning word one cycle later into a 2-entry buffer and presents it on a
// valid/ready stream.
// Optional feature macro: FIFO_RD_STATS_EN adds stat_words / stat_stalls.
// Note: rst_n is active-HIGH (1 = reset) and synchronous, despite the name.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | enable low, no read in flight, buffer empty
//   RUN   | enable high, reads issued whenever a slot is guaranteed
//   DRAIN | enable fell; in-flight word still captured, buffer emptying
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_words,
  output logic [STAT_W-1:0]     stat_stalls
`endif
);

  if (BUF_DEPTH != fifo_rd_pkg::BUF_DEPTH) begin : g_depth_check
    $error("fifo_stream_reader: BUF_DEPTH must be 2");
  end

  rd_state_e state_q;
  rd_state_e state_d;
  logic      inflight;
  occ_t      occ;
  logic      xfer;
  logic [2:0] committed;

  assign m_valid = (occ != 2'd0);
  assign xfer    = m_valid & m_ready;
  assign busy    = inflight | m_valid;

  // Slots already promised after this edge: buffered + returning - leaving.
  // Crediting the pop keeps one word per clock under continuous m_ready.
  assign committed = 3'(occ) + 3'(inflight) - 3'(xfer);

  // Read strobe; the FSM enters RUN on the same edge enable is seen.
  assign fifo_r_en = ~rst_n & enable & ~fifo_empty & (committed < 3'd2);

  // Read-in-flight flag: the FIFO returns data the cycle after r_en.
  always_ff @(posedge clk) begin
    if (rst_n) inflight <= 1'b0;
    else       inflight <= fifo_r_en;
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk  (clk),
    .rst  (rst_n),
    .push (inflight),
    .pop  (xfer),
    .din  (fifo_data_out),
    .dout (m_data),
    .occ  (occ)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = (inflight || m_valid) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (enable)                    state_d = RUN;
        else if (!inflight && !m_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FIFO_RD_STATS_EN
  // Saturating transfer and stall counters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (xfer)                stat_words  <= sat_inc(stat_words);
      if (m_valid && !m_ready) stat_stalls <= sat_inc(stat_stalls);
    end
  end
`endif

endmodule
